// File: rtl/warp_sched_pkg.sv
// Shared warp-scheduler types and constants, also used by the regfile and LSU.
package warp_sched_pkg;

  localparam int NUM_WARPS = 4;
  localparam int WARP_W    = $clog2(NUM_WARPS);

  typedef enum logic [2:0] {
    IDLE,
    READY,
    ISSUED,
    WAIT_MEM,
    EXITED
  } warp_state_e;

  typedef enum logic [1:0] {
    ALU,
    MEM,
    EXIT,
    RSVD
  } done_kind_e;

  // Round-robin successor of a warp id, wrapping the last warp back to 0.
  function automatic logic [WARP_W-1:0] next_warp(input logic [WARP_W-1:0] id);
    return (id == WARP_W'(NUM_WARPS - 1)) ? '0 : id + 1'b1;
  endfunction

  // State a legally retired warp moves to; RSVD is rejected by the caller.
  function automatic warp_state_e retire_state(input done_kind_e kind);
    case (kind)
      ALU:     return READY;
      MEM:     return WAIT_MEM;
      default: return EXITED;
    endcase
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first requester at or after ptr, modulo N.
module rr_arbiter #(
  parameter int N = 4,
  parameter int W = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0] req,
  input  logic [W-1:0] ptr,
  output logic         gnt_valid,
  output logic [W-1:0] gnt_id
);

  int idx;

  // Scan from the farthest position back to ptr so the nearest requester wins.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first, so no path holds an old value and no latch is inferred.
    gnt_valid = 1'b0;
    gnt_id    = '0;
    idx       = 0;
    for (int k = N - 1; k >= 0; k--) begin
      idx = (int'(ptr) + k) % N;
      if (req[idx]) begin
        gnt_valid = 1'b1;
        gnt_id    = W'(idx);
      end
    end
  end

endmodule

// File: rtl/warp_scheduler.sv
// Round-robin warp scheduler: tracks per-warp state, issues one warp at a time,
// parks warps on LSU waits and pulses block_done when every warp has exited.
module warp_scheduler
  import warp_sched_pkg::*;
(
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [2:0]           num_warps,
  input  logic                 issue_ready,
  output logic                 issue_valid,
  output logic [WARP_W-1:0]    issue_warp,
  input  logic                 done_valid,
  input  logic [WARP_W-1:0]    done_warp,
  input  logic [1:0]           done_kind,
  input  logic                 mem_resp_valid,
  input  logic [WARP_W-1:0]    mem_resp_warp,
  output logic                 busy,
  output logic                 block_done,
  output logic [NUM_WARPS-1:0] warp_exited,
  output logic                 proto_err
);

  warp_state_e state_q [NUM_WARPS];
  warp_state_e state_d [NUM_WARPS];

  logic              busy_q, busy_d;
  logic              block_done_q, block_done_d;
  logic              proto_err_q, proto_err_d;
  logic [WARP_W-1:0] rr_ptr_q, rr_ptr_d;

  logic [NUM_WARPS-1:0] ready_vec;
  logic [NUM_WARPS-1:0] issued_vec;
  logic [NUM_WARPS-1:0] exited_vec;
  logic                 gnt_valid;
  logic [WARP_W-1:0]    gnt_id;
  logic                 issue_fire;
  done_kind_e           kind;

  always_comb begin
    for (int i = 0; i < NUM_WARPS; i++) begin
      ready_vec[i]  = (state_q[i] == READY);
      issued_vec[i] = (state_q[i] == ISSUED);
      exited_vec[i] = (state_q[i] == EXITED);
    end
  end

  rr_arbiter #(.N(NUM_WARPS), .W(WARP_W)) u_arb (
    .req       (ready_vec),
    .ptr       (rr_ptr_q),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  // Only one warp may be in the pipeline, so issue waits for the previous retire.
  assign issue_valid = busy_q & ~|issued_vec & gnt_valid;
  assign issue_warp  = gnt_id;
  assign issue_fire  = issue_valid & issue_ready;
  assign kind        = done_kind_e'(done_kind);

  assign busy        = busy_q;
  assign block_done  = block_done_q;
  assign proto_err   = proto_err_q;
  assign warp_exited = exited_vec;

  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    block_done_d = 1'b0;
    proto_err_d  = proto_err_q;
    rr_ptr_d     = rr_ptr_q;

    if (issue_fire) begin
      state_d[gnt_id] = ISSUED;
      rr_ptr_d        = next_warp(gnt_id);
    end

    if (done_valid) begin
      if (state_q[done_warp] == ISSUED && kind != RSVD) begin
        state_d[done_warp] = retire_state(kind);
      end else begin
        proto_err_d = 1'b1;
      end
    end

    // A response colliding with a retire of the same warp is the one rejected.
    if (mem_resp_valid) begin
      if (state_q[mem_resp_warp] == WAIT_MEM &&
          !(done_valid && done_warp == mem_resp_warp)) begin
        state_d[mem_resp_warp] = READY;
      end else begin
        proto_err_d = 1'b1;
      end
    end

    if (busy_q && &exited_vec) begin
      busy_d       = 1'b0;
      block_done_d = 1'b1;
    end

    if (block_done_q) begin
      for (int i = 0; i < NUM_WARPS; i++) state_d[i] = IDLE;
    end

    // Warps beyond the requested count are parked as already exited.
    if (start && !busy_q) begin
      busy_d = 1'b1;
      for (int i = 0; i < NUM_WARPS; i++) begin
        state_d[i] = (int'(num_warps) > i) ? READY : EXITED;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the warp-state array is control state and is reset; a datapath storage array would not need this.
      for (int i = 0; i < NUM_WARPS; i++) state_q[i] <= IDLE;
      busy_q       <= 1'b0;
      block_done_q <= 1'b0;
      proto_err_q  <= 1'b0;
      rr_ptr_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values regardless of statement order.
      for (int i = 0; i < NUM_WARPS; i++) state_q[i] <= state_d[i];
      busy_q       <= busy_d;
      block_done_q <= block_done_d;
      proto_err_q  <= proto_err_d;
      rr_ptr_q     <= rr_ptr_d;
    end
  end

endmodule
